// File: rtl/hazard_forwarding_unit.sv
// Pipeline hazard unit: operand forwarding selects for Decode and Execute, load-use and
// long-latency scoreboard stalls, and a whole-pipeline freeze while a load awaits memory.
module hazard_forwarding_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int MAX_LL     = 4
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [REG_ADDR_W-1:0]         rs1_id,
  input  logic [REG_ADDR_W-1:0]         rs2_id,
  input  logic                          rs1_used_id,
  input  logic                          rs2_used_id,
  input  logic [REG_ADDR_W-1:0]         rd_id,
  input  logic                          ll_issue,
  input  logic [REG_ADDR_W-1:0]         rs1_ex,
  input  logic [REG_ADDR_W-1:0]         rs2_ex,
  input  logic [REG_ADDR_W-1:0]         rd_ex,
  input  logic [REG_ADDR_W-1:0]         rd_mem,
  input  logic [REG_ADDR_W-1:0]         rd_wb,
  input  logic                          reg_we_ex,
  input  logic                          reg_we_mem,
  input  logic                          reg_we_wb,
  input  logic                          mem_read_ex,
  input  logic                          mem_read_mem,
  input  logic                          mem_ack,
  input  logic                          ll_done,
  input  logic [REG_ADDR_W-1:0]         ll_done_rd,
  output logic [1:0]                    forward_rs1_id,
  output logic [1:0]                    forward_rs2_id,
  output logic [1:0]                    forward_rs1_ex,
  output logic [1:0]                    forward_rs2_ex,
  output logic                          stall_id,
  output logic                          stall_all,
  output logic [$clog2(MAX_LL+1)-1:0]   ll_count
);

  localparam int NREG = 2 ** REG_ADDR_W;
  localparam int CW   = $clog2(MAX_LL + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_LL);
  localparam logic [CW-1:0] ONE_CNT = CW'(1);

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_EX   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;
  localparam logic [1:0] FWD_WB   = 2'b11;

  typedef enum logic [0:0] {RUN, MEM_WAIT} state_t;

  state_t          state;
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_next;
  logic [CW-1:0]   count_next;

  logic mem_pending;
  logic ex_ok, mem_ok, wb_ok;
  logic rs1_id_ex, rs1_id_mem, rs1_id_wb;
  logic rs2_id_ex, rs2_id_mem, rs2_id_wb;
  logic rs1_ex_mem, rs1_ex_wb, rs2_ex_mem, rs2_ex_wb;
  logic load_use, raw, waw, full;
  logic done_valid, accept;

  function automatic logic [1:0] pick(input logic hit_ex, input logic hit_mem,
                                      input logic hit_wb);
    if (hit_ex)       return FWD_EX;
    else if (hit_mem) return FWD_MEM;
    else if (hit_wb)  return FWD_WB;
    else              return FWD_NONE;
  endfunction

  assign mem_pending = mem_read_mem && !mem_ack;

  // A producer stage is only eligible once its data actually exists.
  assign ex_ok  = reg_we_ex  && (rd_ex  != '0) && !mem_read_ex;
  assign mem_ok = reg_we_mem && (rd_mem != '0) && !mem_pending;
  assign wb_ok  = reg_we_wb  && (rd_wb  != '0);

  assign rs1_id_ex  = rs1_used_id && (rs1_id == rd_ex)  && ex_ok;
  assign rs1_id_mem = rs1_used_id && (rs1_id == rd_mem) && mem_ok;
  assign rs1_id_wb  = rs1_used_id && (rs1_id == rd_wb)  && wb_ok;
  assign rs2_id_ex  = rs2_used_id && (rs2_id == rd_ex)  && ex_ok;
  assign rs2_id_mem = rs2_used_id && (rs2_id == rd_mem) && mem_ok;
  assign rs2_id_wb  = rs2_used_id && (rs2_id == rd_wb)  && wb_ok;

  assign rs1_ex_mem = (rs1_ex == rd_mem) && mem_ok;
  assign rs1_ex_wb  = (rs1_ex == rd_wb)  && wb_ok;
  assign rs2_ex_mem = (rs2_ex == rd_mem) && mem_ok;
  assign rs2_ex_wb  = (rs2_ex == rd_wb)  && wb_ok;

  always_comb begin
    forward_rs1_id = FWD_NONE;
    forward_rs2_id = FWD_NONE;
    forward_rs1_ex = FWD_NONE;
    forward_rs2_ex = FWD_NONE;
    if (!stall_all) begin
      forward_rs1_id = pick(rs1_id_ex, rs1_id_mem, rs1_id_wb);
      forward_rs2_id = pick(rs2_id_ex, rs2_id_mem, rs2_id_wb);
      forward_rs1_ex = pick(1'b0, rs1_ex_mem, rs1_ex_wb);
      forward_rs2_ex = pick(1'b0, rs2_ex_mem, rs2_ex_wb);
    end
  end

  assign load_use = reg_we_ex && mem_read_ex && (rd_ex != '0) &&
                    ((rs1_used_id && (rs1_id == rd_ex)) ||
                     (rs2_used_id && (rs2_id == rd_ex)));

  assign raw = (rs1_used_id && busy[rs1_id]) || (rs2_used_id && busy[rs2_id]);

  // A result retiring this cycle frees its register and its slot for a same-cycle issue.
  assign done_valid = ll_done && (ll_done_rd != '0) && busy[ll_done_rd] &&
                      (ll_count != '0);
  assign waw  = ll_issue && (rd_id != '0) && busy[rd_id] &&
                !(done_valid && (ll_done_rd == rd_id));
  assign full = ll_issue && (rd_id != '0) && (ll_count == MAX_CNT) && !done_valid;

  assign stall_all = reset_n && mem_pending;
  assign stall_id  = reset_n && !mem_pending && (load_use || raw || waw || full);

  assign accept = ll_issue && (rd_id != '0) && !stall_id && !stall_all && reset_n;

  always_comb begin
    busy_next = busy;
    if (done_valid) busy_next[ll_done_rd] = 1'b0;
    if (accept)     busy_next[rd_id]      = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_comb begin
    count_next = ll_count;
    case ({accept, done_valid})
      2'b10:   count_next = ll_count + ONE_CNT;
      2'b01:   count_next = ll_count - ONE_CNT;
      default: count_next = ll_count;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= RUN;
      busy     <= '0;
      ll_count <= '0;
    end else begin
      busy     <= busy_next;
      ll_count <= count_next;
      case (state)
        RUN:      if (mem_pending) state <= MEM_WAIT;
        MEM_WAIT: if (mem_ack)     state <= RUN;
        default:  state <= RUN;
      endcase
    end
  end

endmodule

// File: doc/hazard_forwarding_unit.md
HAZARD_FORWARDING_UNIT -- requirements
Module: hazard_forwarding_unit

Interface
REQ-001 SHALL have parameter REG_ADDR_W, default 5, register-index width; register file holds 2**REG_ADDR_W entries, x0 hardwired zero.
REQ-002 SHALL have parameter MAX_LL, default 4, maximum outstanding long-latency (mul/div) results, range 1..2**REG_ADDR_W-1.
REQ-003 SHALL have one clock and an asynchronous active-low reset: clock  in  1  rising-edge clock; reset_n  in  1  asynchronous reset, active low.
REQ-004 SHALL have these ports, one per line, as name  direction  width  meaning:
rs1_id, rs2_id  in  REG_ADDR_W  Decode source indices
rs1_used_id, rs2_used_id  in  1  Decode instruction reads that source
rd_id  in  REG_ADDR_W  Decode destination
ll_issue  in  1  Decode instruction is long-latency
rs1_ex, rs2_ex, rd_ex  in  REG_ADDR_W  Execute indices
rd_mem, rd_wb  in  REG_ADDR_W  Memory/WriteBack destinations
reg_we_ex, reg_we_mem, reg_we_wb  in  1  stage writes rd
mem_read_ex, mem_read_mem  in  1  stage holds a load
mem_ack  in  1  data-memory response valid in Memory
ll_done  in  1  long-latency result retires to WriteBack
ll_done_rd  in  REG_ADDR_W  retiring destination
forward_rs1_id, forward_rs2_id, forward_rs1_ex, forward_rs2_ex  out  2  00 none, 01 Ex, 10 Mem, 11 Wb
stall_id  out  1  hold Fetch/Decode, bubble into Execute
stall_all  out  1  freeze whole pipeline
ll_count  out  $clog2(MAX_LL+1)  outstanding long-latency ops

Function
REQ-005 A source matches a stage iff rs==rd, rd!=0, stage reg_we=1; Decode sources also need rs*_used_id=1.
REQ-006 Decode forwarding SHALL be combinational, priority Ex > Mem > Wb; Ex ineligible when mem_read_ex=1; Mem ineligible when mem_read_mem=1 and mem_ack=0.
REQ-007 Execute forwarding SHALL be combinational, priority Mem > Wb, same Mem eligibility rule; Ex never a source for Execute.
REQ-008 Forward outputs SHALL be 00 when no eligible match, including while stall_all=1.
REQ-009 Load-use hazard: used Decode source matches Execute with mem_read_ex=1 -> stall_id=1 same cycle.
REQ-010 Scoreboard: busy bit per register; SHALL set busy[rd_id] at clock edge when ll_issue=1, stall_id=0, stall_all=0, rd_id!=0.
REQ-011 SHALL clear busy[ll_done_rd] at clock edge when ll_done=1; same-cycle set and clear of one index -> bit ends 1.
REQ-012 stall_id SHALL also assert when a used Decode source is busy (RAW), when ll_issue=1 and busy[rd_id]=1 (WAW), or when ll_issue=1 and ll_count==MAX_LL.
REQ-013 ll_count SHALL +1 per accepted issue, -1 per ll_done, unchanged when both; ll_done at ll_count=0 ignored (no underflow).
REQ-014 ll_done for a non-busy index SHALL leave busy unchanged and ll_count unchanged.
REQ-015 FSM states RUN, MEM_WAIT: RUN->MEM_WAIT when mem_read_mem=1 and mem_ack=0; MEM_WAIT->RUN on mem_ack=1.
REQ-016 stall_all SHALL be 1 combinationally whenever mem_read_mem=1 and mem_ack=0 (RUN or MEM_WAIT); 0 otherwise.
REQ-017 stall_all=1 SHALL force stall_id=0 (whole pipe frozen, no bubble) and block scoreboard issue; ll_done still processed.
REQ-018 x0 SHALL never be busy, never forwarded, never stall.

Reset
REQ-019 reset_n=0 SHALL asynchronously clear all busy bits, ll_count=0, FSM=RUN.
REQ-020 During reset stall_id=0, stall_all=0, forwards per REQ-006/007 with empty scoreboard.
REQ-021 Reset mid-MEM_WAIT or with outstanding ops SHALL discard state; later ll_done ignored per REQ-013/014.

Verification
REQ-022 rs1_id=5, rd_ex=5, reg_we_ex=1, mem_read_ex=0, rd_mem=5 -> forward_rs1_id=01; set mem_read_ex=1 -> stall_id=1, forward_rs1_id=10.
REQ-023 rs2_ex=7, rd_mem=7, rd_wb=7, both we=1 -> forward_rs2_ex=10; rd_mem=0 -> 11; rs2_ex=0 -> 00.
REQ-024 ll_issue rd_id=9 accepted -> ll_count=1; next cycle rs1_id=9 used -> stall_id=1; ll_done rd 9 -> next cycle stall_id=0, ll_count=0.
REQ-025 MAX_LL=2: issue rd 3, rd 4, then issue rd 6 -> stall_id=1, ll_count stays 2; same-cycle ll_done rd 3 + issue rd 3 -> busy[3]=1, count 2.
REQ-026 mem_read_mem=1, mem_ack=0 for 3 cycles -> stall_all=1 each cycle, stall_id=0; mem_ack=1 -> stall_all=0, FSM RUN.
REQ-027 Outstanding ops plus MEM_WAIT, pulse reset_n=0 asynchronously -> ll_count=0, stall_all=0 immediately, no busy stalls after release.
